// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: front end of the 16-bit core. Owns the PC, fetches one
// instruction word per request over an imem req/ack handshake and presents
// it to decode over a valid/ready handshake. Downstream redirects replace the
// PC and squash any fetch that is in flight. All outputs are registered.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [15:0]        fetch_count
);

  // DRAIN keeps an abandoned request alive until memory answers it, so the
  // req/ack handshake is never withdrawn mid-flight.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_s;
  logic                load_s;
  logic                accept_s;

  // Only HOLD ever has instr_valid set, so this is the decode handshake.
  assign accept_s = (state_r == ST_HOLD) && instr_valid && instr_ready;

  // Next-state and next-PC selection; a redirect always overrides sequencing.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
        if (redirect) begin
          pc_s = redirect_target;
        end else begin
          pc_s = pc_r;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          // Data returned alongside a redirect belongs to the old path.
          pc_s = redirect_target;
          if (imem_ack) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DRAIN;
          end
        end else if (imem_ack) begin
          load_s  = 1'b1;
          state_s = ST_HOLD;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          // Target wins even if decode accepted in the same cycle.
          pc_s    = redirect_target;
          state_s = ST_REQ;
        end else if (instr_ready) begin
          pc_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          pc_s = redirect_target;
        end else begin
          pc_s = pc_r;
        end
        if (imem_ack) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // State, PC and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= {INSTR_W{1'b0}};
      op          <= 4'h0;
      pc_out      <= RESET_PC;
      fetch_count <= 16'h0000;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      imem_req <= (state_s == ST_REQ) || (state_s == ST_DRAIN);
      // A fresh request always starts at the updated PC; DRAIN keeps the
      // address of the request it is waiting out.
      if (state_s == ST_REQ) begin
        imem_addr <= pc_s;
      end else begin
        imem_addr <= imem_addr;
      end
      if (load_s) begin
        instr       <= imem_rdata;
        op          <= imem_rdata[INSTR_W-1 -: 4];
        pc_out      <= pc_r;
        instr_valid <= 1'b1;
      end else if (state_s != ST_HOLD) begin
        instr_valid <= 1'b0;
      end else begin
        instr_valid <= instr_valid;
      end
      if (accept_s && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end else begin
        fetch_count <= fetch_count;
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 16-bit MIPS-style core: owns the PC and fetches one instruction word per request from instruction memory over a req/ack handshake.
- Presents each instruction, with its 4-bit opcode field, to the decode stage over a valid/ready handshake.
- The opcode feeds the control decoder.
- Accepts redirects (taken branch, jump) computed downstream from the decoder's branch/jump outputs, and squashes any in-flight fetch.

Parameters:
- ADDR_W, 12, word-address width of PC and instruction memory
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request, held until imem_ack
- imem_addr  output  ADDR_W  fetch word address, stable while imem_req=1
- imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle
- imem_rdata  input  INSTR_W  fetched instruction word
- instr_valid  output  1  instr/op/pc_out hold a live instruction
- instr_ready  input  1  decode accepts this cycle
- instr  output  INSTR_W  fetched instruction
- op  output  4  instr[15:12], to control decoder
- pc_out  output  ADDR_W  address of instr
- redirect  input  1  one-cycle pulse: taken branch or jump
- redirect_target  input  ADDR_W  new PC when redirect=1
- fetch_count  output  16  instructions accepted by decode, saturating at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, op=0, pc_out=RESET_PC.
  - fetch_count=0.
  - Reset asserted mid-operation abandons any outstanding request. An imem_ack arriving while in IDLE is ignored.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: one cycle, then REQ. imem_req=0.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, op<=imem_rdata[15:12], pc_out<=pc, instr_valid<=1, go to HOLD.
  - Minimum latency: ack in the first REQ cycle gives instr_valid=1 on the next cycle.
- HOLD:
  - imem_req=0.
  - instr/op/pc_out stay stable while instr_valid=1 and instr_ready=0.
  - On instr_valid&&instr_ready: pc<=pc+1 (wraps 2^ADDR_W-1 to 0), instr_valid<=0, fetch_count++ (saturating), go to REQ.
  - Back-to-back throughput is one instruction per 2 cycles at best; no prefetch.
- Redirect, which has priority over normal sequencing:
  - In HOLD:
    - pc<=redirect_target, instr_valid<=0, go to REQ.
    - If instr_ready was also 1 in that cycle, the handshake counts: fetch_count++. PC still takes the target, not pc+1.
  - In REQ with imem_ack in the same cycle: discard rdata (instr_valid stays 0), pc<=redirect_target, stay in REQ. imem_addr shows the target on the next cycle.
  - In REQ without imem_ack: pc<=redirect_target, go to DRAIN.
  - In DRAIN:
    - imem_req stays 1 and imem_addr keeps the old address, so the handshake is never withdrawn.
    - On imem_ack: discard rdata, go to REQ using the new pc.
    - A further redirect while in DRAIN overwrites pc; the last redirect wins.
  - In IDLE: pc<=redirect_target. Still go to REQ.
- Outputs are registered; there is no combinational path from any input to any output.
- Undefined opcode values are passed through unchanged; decoding them is not this block's concern.

Test Plan:
- Reset, memory returns mem[a]=16'h1000+a with ack one cycle after req, instr_ready tied 1 -> issues addresses 0,1,2,3 in order; op=4'h1; pc_out matches; fetch_count=4 after the 4th accept.
- instr_ready held 0 for 5 cycles with instr_valid=1 -> instr/op/pc_out constant, imem_req=0, pc not advanced; the accept on cycle 6 gives next imem_addr=pc_out+1.
- Redirect to 12'h080 while REQ waiting (ack delayed 3 cycles) -> imem_addr holds the old address until ack, data discarded (instr_valid never 1), then req at 12'h080; first issued pc_out=12'h080.
- Redirect to 12'h010 coincident with instr_valid&&instr_ready in HOLD -> fetch_count increments by 1; next imem_addr=12'h010, not pc+1.
- Redirect coincident with imem_ack in REQ -> no instr_valid for that data; next imem_addr=target.
- RESET_PC=12'hFFF: first accept -> next imem_addr=12'h000 (wrap). Reset asserted while imem_req=1 -> next cycle imem_req=0, instr_valid=0, imem_addr=RESET_PC, and a late ack is ignored.
